// File: rtl/class_pkg.sv
// Shared definitions for the class merge path: word geometry, grant
// state encoding and the class-bit consistency check.
package class_pkg;

  localparam int DATA_W    = 10;
  localparam int CLASS_BIT = 8;
  localparam int WEIGHT    = 3;

  // Last-grant state of the output arbiter.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  // True when a word's class bit does not match the FIFO it came from.
  function automatic logic class_bad(input logic cls_bit, input logic src_class);
    return (cls_bit != src_class);
  endfunction

endpackage

// File: rtl/wrr_credit_cnt.sv
// Saturating credit counter that bounds consecutive class 1 grants while
// class 0 has a word waiting. at_limit tells the arbiter to serve class 0.
module wrr_credit_cnt #(
  parameter int WEIGHT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic grant1,
  input  logic grant0,
  input  logic hold,
  input  logic pend0,
  output logic at_limit
);

  localparam int CNT_W = $clog2(WEIGHT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WEIGHT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next credit value: an empty class 0 or a class 0 grant restarts the
  // count; back-pressure freezes it; class 1 grants advance it to LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (!pend0 || grant0) begin
      cnt_d = '0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (grant1 && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Credit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q >= LIMIT);

endmodule

// File: rtl/class_out_arbiter.sv
// Merges the class 0 and class 1 FIFO streams onto one registered output.
// Class 1 wins contention until it has taken WEIGHT grants in a row while
// class 0 waits; then class 0 is served once. Pops are suppressed while
// the downstream reports almost-full.
module class_out_arbiter
  import class_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int WEIGHT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo0_data,
  input  logic              fifo0_empty,
  output logic              fifo0_pop,
  input  logic [DATA_W-1:0] fifo1_data,
  input  logic              fifo1_empty,
  output logic              fifo1_pop,
  input  logic              out_almost_full,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              grant_class,
  output logic              class_err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              pop0_s, pop1_s;
  logic              at_limit_s;
  logic              req0_s, req1_s;

  assign req0_s = !fifo0_empty;
  assign req1_s = !fifo1_empty;

  wrr_credit_cnt #(
    .WEIGHT(WEIGHT)
  ) u_credit (
    .clk     (clk),
    .reset   (reset),
    .grant1  (pop1_s),
    .grant0  (pop0_s),
    .hold    (out_almost_full),
    .pend0   (req0_s),
    .at_limit(at_limit_s)
  );

  // Pop decision: nothing under reset or back-pressure, credit-weighted
  // choice under contention, otherwise serve whichever FIFO has data.
  always_comb begin
    pop0_s = 1'b0;
    pop1_s = 1'b0;
    if (reset || out_almost_full) begin
      pop0_s = 1'b0;
      pop1_s = 1'b0;
    end else if (req0_s && req1_s) begin
      if (at_limit_s) begin
        pop0_s = 1'b1;
      end else begin
        pop1_s = 1'b1;
      end
    end else if (req0_s) begin
      pop0_s = 1'b1;
    end else if (req1_s) begin
      pop1_s = 1'b1;
    end else begin
      pop0_s = 1'b0;
      pop1_s = 1'b0;
    end
  end

  // Next state of the last-grant FSM, output word and sticky class error.
  always_comb begin
    state_d = IDLE;
    data_d  = data_q;
    valid_d = pop0_s | pop1_s;
    err_d   = err_q;
    if (pop1_s) begin
      state_d = G1;
      data_d  = fifo1_data;
      err_d   = err_q | class_bad(fifo1_data[CLASS_BIT], 1'b1);
    end else if (pop0_s) begin
      state_d = G0;
      data_d  = fifo0_data;
      err_d   = err_q | class_bad(fifo0_data[CLASS_BIT], 1'b0);
    end else begin
      state_d = IDLE;
    end
  end

  // State and output registers; reset drops any word still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign fifo0_pop   = pop0_s;
  assign fifo1_pop   = pop1_s;
  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign grant_class = (state_q == G1);
  assign class_err   = err_q;

endmodule

// File: doc/class_out_arbiter.md
# class_out_arbiter

Weighted arbiter that merges the two per-class word streams produced by the class-splitting stage back onto a single output channel. It sits downstream of the class 0 and class 1 FIFOs that buffer the split words. It pops one word per cycle from the selected FIFO, giving class 1 priority bounded by a programmable weight so that class 0 cannot starve. Output is registered and respects downstream almost-full back-pressure.

## Interface
- DATA_W, 10, word width; bit 8 is the class bit, all bits forwarded unchanged
- WEIGHT, 3, max consecutive class 1 grants while class 0 is pending (≥1)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- fifo0_data  in  DATA_W  head word of class 0 FIFO (show-ahead, valid when not empty)
- fifo0_empty  in  1  class 0 FIFO empty
- fifo0_pop  out  1  consume head of class 0 FIFO this cycle
- fifo1_data  in  DATA_W  head word of class 1 FIFO
- fifo1_empty  in  1  class 1 FIFO empty
- fifo1_pop  out  1  consume head of class 1 FIFO this cycle
- out_almost_full  in  1  downstream can accept at most one more word
- data_out  out  DATA_W  registered merged word
- valid_out  out  1  data_out holds a new word this cycle
- grant_class  out  1  class of last granted word (registered)
- class_err  out  1  sticky: a popped word's bit 8 disagreed with its source FIFO

## Operation
- Pops are combinational from the registered state plus current inputs; at most one pop per cycle; both pops are 0 while reset=1 or out_almost_full=1.
- FSM (last grant): IDLE, G0, G1. No pop → IDLE; pop0 → G0; pop1 → G1. grant_class = 1 in G1, else 0.
- Credit counter cnt, width clog2(WEIGHT+1):
  - Both FIFOs non-empty: grant class 1 if cnt < WEIGHT, else grant class 0.
  - Only one non-empty: grant it.
  - Class 1 grant with fifo0 non-empty: cnt += 1, saturating at WEIGHT.
  - Class 0 grant, or cycle with fifo0_empty=1: cnt ← 0.
  - Back-pressure cycle with fifo0 non-empty: cnt frozen.
- Popped word is loaded into data_out at the next edge with valid_out=1. Cycles without a pop: valid_out=0, data_out holds its last value (not cleared).
- class_err set when popped fifo0 word has bit 8 = 1 or fifo1 word has bit 8 = 0. The word is still forwarded. Cleared only by reset.
- Reset values: data_out 0, valid_out 0, grant_class 0, class_err 0, cnt 0, FSM IDLE.

## Timing
- Latency: pop in cycle N → data_out/valid_out valid in cycle N+1.
- out_almost_full is sampled in the same cycle as the pop decision. At most one word is in flight after it asserts, so downstream must keep one slot of margin.
- FIFO empty flags are sampled in the pop cycle. Empty and not-empty at the same time for the other class follows the single-requester rule.
- Reset mid-operation: pops forced low during the reset cycle. A word popped in the cycle before reset is still presented, but the reset edge wins: valid_out is 0 after the reset edge and that word is dropped.
- Throughput: one word per cycle when any FIFO is non-empty and not back-pressured.

## Structure
- Shared package class_pkg: DATA_W, CLASS_BIT (=8), state encoding constants (IDLE/G0/G1).
- One sub-module, wrr_credit_cnt: the saturating credit counter. Inputs are grant1, grant0, hold and pend0; output is the at_limit flag.
- Top holds the FSM, pop logic, output register and error flag.

## Test plan
- Reset held 2 cycles with both FIFOs non-empty → pops 0, data_out 0x000, valid_out 0, class_err 0, grant_class 0.
- Only fifo0, words 0x001,0x002 → fifo0_pop cycles 0,1; data_out 0x001 then 0x002 in cycles 1,2 with valid_out=1; then valid_out=0, data_out stays 0x002.
- Both FIFOs continuously non-empty, WEIGHT=3 → grant sequence 1,1,1,0,1,1,1,0; grant_class follows one cycle later.
- out_almost_full asserted for 3 cycles mid-sequence (after two class 1 grants) → pops 0 same cycle, valid_out 0 next cycle; on release, one more class 1 grant then class 0 (cnt frozen at 2).
- fifo0 head 0x100 (bit 8 = 1) → forwarded as data_out 0x100; class_err=1 and stays 1 until reset.
- Reset in the cycle after a class 1 pop → valid_out 0, cnt 0, FSM IDLE; after release with both pending, the first three grants are class 1.
